// File: rtl/bitfield_pkg.sv
// Shared types and constants for the bit-field unpacker.
// Holds the FSM state encoding, the datapath widths and the field-length legality check.
package bitfield_pkg;

  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int LEN_W  = 6;
  localparam int LVL_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } state_e;

  // Field lengths of 1..32 bits are the only ones the extractor can serve.
  function automatic logic is_legal_len(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(WORD_W));
  endfunction

endpackage

// File: rtl/bitfield_unpacker_if.sv
// Word-input, field-request and field-output handshakes of the bit-field unpacker.
// The master modport is the surrounding system; the slave modport is the unpacker itself.
interface bitfield_unpacker_if;
  import bitfield_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              req_valid;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len;
  logic              req_sign;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (
    output in_valid, in_data, req_valid, req_len, req_sign, out_ready,
    input  in_ready, req_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, req_valid, req_len, req_sign, out_ready,
    output in_ready, req_ready, out_valid, out_data
  );

endinterface

// File: rtl/bitfield_extract.sv
// Combinational field extractor: keeps the low len bits of data and zero- or sign-extends them.
// An illegal length produces zero.
module bitfield_extract
  import bitfield_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  input  logic              sign,
  output logic [WORD_W-1:0] field
);

  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] masked;
  logic [WORD_W-1:0] top;
  logic              msb;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len);
    end
  endgenerate

  always_comb begin
    masked = data & mask;
    top    = masked >> (len - LEN_W'(1));
    msb    = top[0];
    field  = (sign && msb) ? (masked | ~mask) : masked;
    if (!is_legal_len(len)) begin
      field = '0;
    end
  end

endmodule

// File: rtl/bitfield_unpacker.sv
// Bit-field unpacker: buffers 32-bit words in a 64-bit shift register and hands out
// LSB-first fields of 1..32 bits, one request at a time, through an IDLE/PEND/HOLD FSM.
module bitfield_unpacker
  import bitfield_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  bitfield_unpacker_if.slave bus,
  input  logic               flush,
  output logic [LVL_W-1:0]   level,
  output logic               err
);

  state_e            state_reg;
  logic [BUF_W-1:0]  data_buf_reg;
  logic [BUF_W-1:0]  buf_mid;
  logic [BUF_W-1:0]  buf_next;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  level_mid;
  logic [LVL_W-1:0]  level_next;
  logic [LVL_W-1:0]  shift_amt;
  logic [LEN_W-1:0]  len_reg;
  logic              sign_reg;
  logic              out_valid_reg;
  logic [WORD_W-1:0] out_data_reg;
  logic              err_reg;
  logic [WORD_W-1:0] field;
  logic              accept;
  logic              extract_fire;
  logic              flush_fire;
  logic              push;

  assign bus.in_ready  = (level_reg <= LVL_W'(WORD_W));
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign level         = level_reg;
  assign err           = err_reg;

  assign accept       = bus.req_valid && (state_reg == IDLE);
  assign extract_fire = (state_reg == PEND) && (level_reg >= {1'b0, len_reg});
  assign flush_fire   = flush && (state_reg == IDLE) && !accept;
  assign push         = bus.in_valid && bus.in_ready;

  // Extraction and flush are mutually exclusive, so one shifter serves both;
  // a same-cycle push lands just above whatever survives the shift.
  always_comb begin
    shift_amt = '0;
    if (extract_fire) begin
      shift_amt = {1'b0, len_reg};
    end else if (flush_fire) begin
      shift_amt = {2'b00, level_reg[4:0]};
    end
    buf_mid    = data_buf_reg >> shift_amt;
    level_mid  = level_reg - shift_amt;
    buf_next   = buf_mid;
    level_next = level_mid;
    if (push) begin
      buf_next   = buf_mid | ({{(BUF_W-WORD_W){1'b0}}, bus.in_data} << level_mid);
      level_next = level_mid + LVL_W'(WORD_W);
    end
  end

  bitfield_extract u_extract (
    .data  (data_buf_reg[WORD_W-1:0]),
    .len   (len_reg),
    .sign  (sign_reg),
    .field (field)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_buf_reg <= '0;
      level_reg    <= '0;
    end else begin
      data_buf_reg <= buf_next;
      level_reg    <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      sign_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            len_reg  <= bus.req_len;
            sign_reg <= bus.req_sign;
            if (is_legal_len(bus.req_len)) begin
              state_reg <= PEND;
            end else begin
              // Bad length: answer with zero immediately and consume nothing.
              err_reg       <= 1'b1;
              out_data_reg  <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= HOLD;
            end
          end
        end
        PEND: begin
          if (extract_fire) begin
            out_data_reg  <= field;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitfield_unpacker.sv
// Directed bench for bitfield_unpacker: hand-computed fields, levels, stalls, flush and error flag.
module tb_bitfield_unpacker;
  import bitfield_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [LVL_W-1:0] level;
  logic             err;

  bitfield_unpacker_if bus ();

  bitfield_unpacker dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .level (level),
    .err   (err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_value("push_timeout", 64'd0, 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic request(input logic [5:0] len, input logic sign,
                         output logic [31:0] data, output int lat);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_len   = len;
    bus.req_sign  = sign;
    tick();
    bus.req_valid = 1'b0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_value("req_timeout", 64'd0, 64'd1);
    lat  = n;
    data = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [31:0] d;
  int          lat;

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.req_valid = 1'b0;
    bus.req_len   = '0;
    bus.req_sign  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_value("rst_level", level, 0);
    check_value("rst_out_valid", bus.out_valid, 0);
    check_value("rst_out_data", bus.out_data, 0);
    check_value("rst_err", err, 0);
    check_value("rst_in_ready", bus.in_ready, 1);
    check_value("rst_req_ready", bus.req_ready, 1);

    // 1: three fields from one word
    push_word(32'hDEADBEEF);
    check_value("t1_level_push", level, 32);
    request(6'd4, 1'b0, d, lat);
    check_value("t1_f4", d, 32'h0000000F);
    check_value("t1_latency", lat, 1);
    check_value("t1_level_28", level, 28);
    request(6'd8, 1'b0, d, lat);
    check_value("t1_f8", d, 32'h000000EE);
    check_value("t1_level_20", level, 20);
    request(6'd20, 1'b0, d, lat);
    check_value("t1_f20", d, 32'h000DEADB);
    check_value("t1_level_0", level, 0);

    // 2: signed vs unsigned byte
    push_word(32'h00000080);
    request(6'd8, 1'b1, d, lat);
    check_value("t2_signed", d, 32'hFFFFFF80);
    do_flush();
    check_value("t2_flush_level", level, 0);
    push_word(32'h00000080);
    request(6'd8, 1'b0, d, lat);
    check_value("t2_unsigned", d, 32'h00000080);
    do_flush();

    // 3: field straddling two words
    push_word(32'h12345678);
    request(6'd24, 1'b0, d, lat);
    check_value("t3_f24", d, 32'h00345678);
    check_value("t3_level_8", level, 8);
    push_word(32'h9ABCDEF0);
    request(6'd16, 1'b0, d, lat);
    check_value("t3_f16", d, 32'h0000F012);
    check_value("t3_level_24", level, 24);
    do_flush();
    check_value("t3_flush_level", level, 0);

    // 4: full buffer stalls the third word
    push_word(32'hCAFEF00D);
    do_flush();
    check_value("t4_flush_at_32", level, 32);
    push_word(32'h0BADBEEF);
    check_value("t4_level_64", level, 64);
    check_value("t4_in_ready_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h13579BDF;
    repeat (3) tick();
    check_value("t4_stalled_level", level, 64);
    request(6'd32, 1'b0, d, lat);
    bus.in_valid = 1'b0;
    check_value("t4_word_a", d, 32'hCAFEF00D);
    check_value("t4_third_taken", level, 64);
    request(6'd32, 1'b0, d, lat);
    check_value("t4_word_b", d, 32'h0BADBEEF);
    request(6'd32, 1'b0, d, lat);
    check_value("t4_word_c", d, 32'h13579BDF);
    check_value("t4_level_0", level, 0);

    // 5: request waits for data, then output is held
    bus.req_valid = 1'b1;
    bus.req_len   = 6'd8;
    bus.req_sign  = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    check_value("t5_pend_no_valid", bus.out_valid, 0);
    check_value("t5_pend_req_ready", bus.req_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h000000A5;
    tick();
    bus.in_valid = 1'b0;
    check_value("t5_not_early", bus.out_valid, 0);
    tick();
    check_value("t5_valid", bus.out_valid, 1);
    check_value("t5_data", bus.out_data, 32'h000000A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("t5_hold_data", bus.out_data, 32'h000000A5);
    end
    check_value("t5_hold_valid", bus.out_valid, 1);
    check_value("t5_hold_req_ready", bus.req_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_value("t5_released", bus.out_valid, 0);
    check_value("t5_level_24", level, 24);
    do_flush();

    // 6: flush, illegal lengths, sticky err, full-width signed field
    push_word(32'hAABBCCDD);
    request(6'd8, 1'b0, d, lat);
    check_value("t6_f8", d, 32'h000000DD);
    check_value("t6_level_24", level, 24);
    do_flush();
    check_value("t6_flush_level", level, 0);
    request(6'd0, 1'b0, d, lat);
    check_value("t6_len0_data", d, 0);
    check_value("t6_len0_latency", lat, 0);
    check_value("t6_err_set", err, 1);
    check_value("t6_len0_level", level, 0);
    push_word(32'h80000000);
    request(6'd33, 1'b0, d, lat);
    check_value("t6_len33_data", d, 0);
    check_value("t6_len33_level", level, 32);
    request(6'd32, 1'b1, d, lat);
    check_value("t6_f32_signed", d, 32'h80000000);
    check_value("t6_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("t6_err_cleared", err, 0);
    check_value("t6_rst_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
